btb_update_ctrl: RTL
====================

# btb_update_ctrl

Controller for the branch target buffer (BTB) write port and the branch redirect path. It checks each branch resolved in EX against its IF-stage prediction and issues the flush and redirect PC on a mispredict. It schedules BTB writes through a one-entry registered update stage. After reset and on software request, it runs an invalidate sweep that takes over the write port and suppresses lookups until the BTB is clean.

## Interface
- BTB_ENTRIES, 1024: number of BTB entries; power of two; index = pc[IDX_W+1:2], tag = pc[31:12]
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- predictor_en  in  1  predictor enable
- inv_all_i  in  1  one-cycle pulse requesting a full BTB invalidate
- valid_EX  in  1  EX holds a valid instruction
- instr_EX  in  32  EX instruction; opcode in [6:0]
- pc_EX  in  32  EX pc
- taken_EX  in  1  branch resolved taken
- aludata_EX  in  32  resolved branch target
- pred_hit_EX  in  1  this instruction was predicted taken in IF
- pred_target_EX  in  32  target predicted in IF
- flush_br  out  1  flush IF/ID; combinational
- npc  out  32  redirect pc, valid when flush_br=1
- lookup_en_o  out  1  IF may use BTB hits
- busy_o  out  1  sweep in progress
- btb_we_o  out  1  BTB write strobe
- btb_idx_o  out  IDX_W  write index
- btb_tag_o  out  20  write tag
- btb_target_o  out  32  write target
- btb_valid_o  out  1  write valid bit
- br_cnt_o  out  32  resolved branches (see Configuration)
- mispred_cnt_o  out  32  mispredicts (see Configuration)

## Operation
- FSM states: SWEEP, RUN. Reset enters SWEEP with sweep_idx=0.
- SWEEP:
  - each cycle drives btb_we_o=1, btb_idx_o=sweep_idx, btb_valid_o=0, btb_tag_o=0, btb_target_o=0.
  - at sweep_idx=BTB_ENTRIES-1, go to RUN; the counter wraps to 0.
- RUN: inv_all_i=1 goes to SWEEP with sweep_idx=0 and clears any pending update.
- br = valid_EX & predictor_en & (instr_EX[6:0]==OPC_BRANCH).
- Mispredict decode when br=1:
  - taken_EX & (!pred_hit_EX | pred_target_EX!=aludata_EX): flush, npc=aludata_EX, update {valid=1, target=aludata_EX}.
  - !taken_EX & pred_hit_EX: flush, npc=pc_EX+4 (mod 2^32), update {valid=0}.
  - otherwise: no flush, no update.
- Updates:
  - Captured into the update register only in RUN, and only if inv_all_i=0 that cycle.
  - Written on the next cycle with idx/tag derived from pc_EX.
  - One update per cycle; the register is overwritten each cycle, so no backpressure is needed.
- During SWEEP:
  - flush/npc decode still operates, because the pipeline must still be corrected.
  - Updates are dropped.
- predictor_en=0: flush_br=0, no updates, lookup_en_o=0. The sweep still runs.
- lookup_en_o = predictor_en & (state==RUN).
- busy_o = (state==SWEEP).

## Timing
- Reset values: state=SWEEP, sweep_idx=0, update register empty, counters 0.
- While rst_i=1 (checked at the clock edge), all registered outputs are at reset values and btb_we_o=0.
- The first sweep write occurs in the first cycle after rst_i deasserts.
- Sweep length is exactly BTB_ENTRIES cycles; lookup_en_o rises the cycle after the last write.
- flush_br/npc: zero latency, combinational from EX inputs.
- BTB update: btb_we_o asserts exactly 1 cycle after the resolving EX cycle.
- inv_all_i in the same cycle as a mispredict: flush is still issued, the update is dropped, and SWEEP starts next cycle.
- inv_all_i during SWEEP: sweep_idx restarts at 0.
- Reset mid-sweep: restart from idx 0.

## Configuration
- BP_STATS_EN defined:
  - br_cnt_o increments on each br.
  - mispred_cnt_o increments on each flush.
  - Both are 32-bit, wrap at 2^32, and are cleared only by rst_i.
- BP_STATS_EN undefined: the ports remain and are tied to 0; no counter flops.

## Structure
- Shared package bp_pkg holds:
  - OPC_BRANCH = 7'b1100011
  - BTB_TAG_W = 20
  - IDX_W = $clog2(BTB_ENTRIES)
  - the state enum {SWEEP, RUN}
  - the update-register struct {idx, tag, target, valid, pend}
- One sub-module, btb_sweeper:
  - holds the sweep counter and done flag.
  - inputs: start, rst_i.
  - outputs: idx, last.

## Test plan
- Reset with BTB_ENTRIES=16 -> btb_we_o high for 16 cycles, idx 0..15, valid=0; lookup_en_o=1 on cycle 17.
- RUN, branch pc_EX=0x1000, taken, aludata_EX=0x1040, pred_hit_EX=0 -> same cycle: flush_br=1, npc=0x1040. Next cycle: we=1, idx=0x0, tag=0x00001, target=0x1040, valid=1.
- Branch pc_EX=0x2008, not taken, pred_hit_EX=1 -> flush_br=1, npc=0x200C. Next cycle: write idx=2, valid=0.
- Branch pc_EX=0x1000, taken, predicted hit with target 0x1040 -> flush_br=0, no write.
- inv_all_i pulsed together with a mispredict -> flush_br=1 that cycle, no update write, sweep begins next cycle, lookup_en_o=0 for 16 cycles.
- BP_STATS_EN: 3 branches, 2 mispredicts -> br_cnt_o=3, mispred_cnt_o=2. Without the macro, both read 0.

Source files
------------

// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared definitions for the branch predictor update path: branch opcode,
// BTB tag width, the controller state type, the registered update-slot record,
// and the index-width helper.
// -----------------------------------------------------------------------------
package bp_pkg;

  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam int         BTB_TAG_W     = 20;
  // Widest possible word index (pc[31:2]). Each instance slices its own IDX_W
  // bits out of this field.
  localparam int         BTB_IDX_MAX_W = 30;

  // IDX_W for a BTB with the given number of entries.
  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  typedef enum logic {
    SWEEP = 1'b0,
    RUN   = 1'b1
  } btb_state_e;

  typedef struct packed {
    logic [BTB_IDX_MAX_W-1:0] idx;
    logic [BTB_TAG_W-1:0]     tag;
    logic [31:0]              target;
    logic                     valid;
    logic                     pend;
  } btb_upd_t;

endpackage

// File: rtl/btb_sweeper.sv
// -----------------------------------------------------------------------------
// btb_sweeper
// Index generator for the BTB invalidate sweep. The sweep starts at index 0
// after reset or a start pulse. It steps one entry per cycle. On the last
// entry it wraps to 0 and parks in a done state.
//
// Ports
//   clk_i  : clock
//   rst_i  : synchronous active-high reset (restarts the sweep at 0)
//   start  : restart the sweep at index 0 on the next cycle
//   idx    : entry being cleared this cycle
//   last   : this cycle clears the final entry
// -----------------------------------------------------------------------------
module btb_sweeper #(
  parameter int ENTRIES = 1024,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [IDX_W-1:0] idx_q;
  logic             done_q;

  assign idx  = idx_q;
  assign last = !done_q && (idx_q == IDX_W'(ENTRIES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || start) begin
      idx_q  <= '0;
      done_q <= 1'b0;
    end else if (!done_q) begin
      if (last) begin
        idx_q  <= '0;
        done_q <= 1'b1;
      end else begin
        idx_q  <= idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/btb_update_ctrl.sv
// -----------------------------------------------------------------------------
// btb_update_ctrl
// BTB write-port and branch-redirect controller. The block checks each branch
// resolved in EX against its IF prediction. On a mispredict it raises a
// combinational flush with the redirect pc. It also schedules the corrective
// BTB write through a one-entry update register, so the write lands one cycle
// later. After reset, and on inv_all_i, an invalidate sweep takes over the
// write port and keeps IF from using BTB hits until every entry is cleared.
//
// Build option: define BP_STATS_EN to enable the branch/mispredict counters.
// Without it, br_cnt_o and mispred_cnt_o read 0.
//
// Ports
//   clk_i, rst_i           : clock, synchronous active-high reset
//   predictor_en           : predictor enable (gates flush, updates, lookups)
//   inv_all_i              : pulse requesting a full BTB invalidate
//   valid_EX, instr_EX,    : EX-stage instruction, pc, resolved direction,
//   pc_EX, taken_EX,         resolved target
//   aludata_EX
//   pred_hit_EX,           : IF-stage prediction carried down to EX
//   pred_target_EX
//   flush_br, npc          : redirect (combinational from EX)
//   lookup_en_o, busy_o    : IF may use BTB hits / sweep in progress
//   btb_we_o, btb_idx_o,   : BTB write port
//   btb_tag_o, btb_target_o,
//   btb_valid_o
//   br_cnt_o,              : statistics counters
//   mispred_cnt_o
// -----------------------------------------------------------------------------
module btb_update_ctrl
  import bp_pkg::*;
#(
  parameter  int BTB_ENTRIES = 1024,
  localparam int IDX_W       = bp_pkg::idx_w(BTB_ENTRIES)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 predictor_en,
  input  logic                 inv_all_i,
  input  logic                 valid_EX,
  input  logic [31:0]          instr_EX,
  input  logic [31:0]          pc_EX,
  input  logic                 taken_EX,
  input  logic [31:0]          aludata_EX,
  input  logic                 pred_hit_EX,
  input  logic [31:0]          pred_target_EX,
  output logic                 flush_br,
  output logic [31:0]          npc,
  output logic                 lookup_en_o,
  output logic                 busy_o,
  output logic                 btb_we_o,
  output logic [IDX_W-1:0]     btb_idx_o,
  output logic [BTB_TAG_W-1:0] btb_tag_o,
  output logic [31:0]          btb_target_o,
  output logic                 btb_valid_o,
  output logic [31:0]          br_cnt_o,
  output logic [31:0]          mispred_cnt_o
);

  btb_state_e       state_q, state_d;
  logic             sweep_start;
  logic             sweep_last;
  logic [IDX_W-1:0] sweep_idx;
  logic             br;
  logic             mis_taken;
  logic             mis_not_taken;
  btb_upd_t         upd_p0;
  btb_upd_t         upd_p1;
  logic             unused_bits;

  // ---- p0: EX-stage resolve against the IF prediction ----------------------
  assign br            = valid_EX & predictor_en & (instr_EX[6:0] == OPC_BRANCH);
  assign mis_taken     = br & taken_EX & (!pred_hit_EX | (pred_target_EX != aludata_EX));
  assign mis_not_taken = br & !taken_EX & pred_hit_EX;

  assign flush_br = mis_taken | mis_not_taken;
  assign npc      = mis_taken ? aludata_EX : (pc_EX + 32'd4);

  // A not-taken mispredict writes valid=0, so the entry no longer redirects IF.
  // The same record also carries the target and tag. They are ignored when
  // valid is 0.
  always_comb begin
    upd_p0        = '0;
    upd_p0.idx    = pc_EX[31:2];
    upd_p0.tag    = pc_EX[31:12];
    upd_p0.target = aludata_EX;
    upd_p0.valid  = mis_taken;
    upd_p0.pend   = flush_br & (state_q == RUN) & !inv_all_i;
  end

  // ---- p1: registered update slot, overwritten every cycle -----------------
  always_ff @(posedge clk_i) begin
    upd_p1 <= upd_p0;
    if (rst_i) begin
      upd_p1.pend <= 1'b0;
    end
  end

  // ---- sweep control --------------------------------------------------------
  btb_sweeper #(
    .ENTRIES (BTB_ENTRIES),
    .IDX_W   (IDX_W)
  ) u_sweeper (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .start (sweep_start),
    .idx   (sweep_idx),
    .last  (sweep_last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SWEEP;
    end else begin
      state_q <= state_d;
    end
  end

  // inv_all_i restarts the sweep from either state. In SWEEP, it takes
  // priority over finishing on the last entry.
  always_comb begin
    state_d     = state_q;
    sweep_start = 1'b0;
    case (state_q)
      SWEEP: begin
        if (inv_all_i) begin
          sweep_start = 1'b1;
        end else if (sweep_last) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (inv_all_i) begin
          state_d     = SWEEP;
          sweep_start = 1'b1;
        end
      end
      default: state_d = SWEEP;
    endcase
  end

  // ---- BTB write port -------------------------------------------------------
  // The sweep owns the port. An update can never be pending in SWEEP, because
  // capture is blocked there. The write strobe is held off while reset is
  // asserted, so the first sweep write lands in the first cycle after reset.
  assign btb_we_o     = !rst_i & ((state_q == SWEEP) | upd_p1.pend);
  assign btb_idx_o    = (state_q == SWEEP) ? sweep_idx : upd_p1.idx[IDX_W-1:0];
  assign btb_tag_o    = (state_q == SWEEP) ? '0 : upd_p1.tag;
  assign btb_target_o = (state_q == SWEEP) ? '0 : upd_p1.target;
  assign btb_valid_o  = (state_q == SWEEP) ? 1'b0 : upd_p1.valid;

  assign lookup_en_o  = predictor_en & (state_q == RUN);
  assign busy_o       = (state_q == SWEEP);

  // Index bits above this BTB's size, and the non-opcode instruction bits, are
  // intentionally unused.
  assign unused_bits  = ^{instr_EX[31:7], upd_p1.idx[BTB_IDX_MAX_W-1:IDX_W]};

  // ---- statistics -----------------------------------------------------------
`ifdef BP_STATS_EN
  logic [31:0] br_cnt_q;
  logic [31:0] mispred_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      br_cnt_q      <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (br) begin
        br_cnt_q <= br_cnt_q + 32'd1;
      end
      if (flush_br) begin
        mispred_cnt_q <= mispred_cnt_q + 32'd1;
      end
    end
  end

  assign br_cnt_o      = br_cnt_q;
  assign mispred_cnt_o = mispred_cnt_q;
`else
  assign br_cnt_o      = '0;
  assign mispred_cnt_o = '0;
`endif

endmodule
